// File: rtl/sub_op_sequencer_if.sv
// sub_op_sequencer_if
//   Bundles the three signal groups around the subtractor sequencer:
//     in_*   request handshake (valid/ready) carrying operands and mode
//     sub_*  drive to / results from the Subtractor
//     out_*  response handshake (valid/ready) carrying the captured result
//     busy   sequencer status
//   Modports:
//     slave  - the sequencer itself
//     master - the environment: requester, Subtractor and response consumer
interface sub_op_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_bin;
  logic             in_mode;

  logic             sub_sel;
  logic             sub_start;
  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic             sub_bin;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_bout;
  logic             sub_done;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_bout;
  logic             out_mode;
  logic [CNT_W-1:0] out_cycles;
  logic             out_err;

  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_bin, in_mode,
    output in_ready,
    output sub_sel, sub_start, sub_a, sub_b, sub_bin,
    input  sub_diff, sub_bout, sub_done,
    output out_valid, out_diff, out_bout, out_mode, out_cycles, out_err,
    input  out_ready,
    output busy
  );

  modport master (
    output in_valid, in_a, in_b, in_bin, in_mode,
    input  in_ready,
    input  sub_sel, sub_start, sub_a, sub_b, sub_bin,
    output sub_diff, sub_bout, sub_done,
    input  out_valid, out_diff, out_bout, out_mode, out_cycles, out_err,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/sub_op_sequencer.sv
// sub_op_sequencer
//   Command/response stage in front of the 32-bit Subtractor. Accepts one
//   request, drives it into the Subtractor, waits for the result (first WAIT
//   edge in parallel mode, sub_done in serial mode), captures diff/bout and
//   returns them with the number of WAIT cycles spent.
//   FSM: IDLE -> ISSUE -> WAIT -> HOLD -> IDLE. All outputs are registered.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    sub_op_sequencer_if.slave (request, Subtractor and response groups)
// Parameters
//   WIDTH    operand/result width
//   CNT_W    WAIT counter and out_cycles width
//   TIMEOUT  serial WAIT cycle limit (exists only with SUB_SEQ_TIMEOUT_EN)
// Configuration
//   SUB_SEQ_TIMEOUT_EN  when defined, a serial op whose done never arrives is
//                       retired after TIMEOUT WAIT cycles with out_err=1.
//                       When undefined, WAIT holds until sub_done and out_err
//                       is tied to 0.
module sub_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
`ifdef SUB_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT = 40
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  sub_op_sequencer_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef SUB_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
`endif

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;

`ifndef SUB_SEQ_TIMEOUT_EN
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      bus.in_ready   <= 1'b0;
      bus.sub_sel    <= 1'b0;
      bus.sub_start  <= 1'b0;
      bus.sub_a      <= {WIDTH{1'b0}};
      bus.sub_b      <= {WIDTH{1'b0}};
      bus.sub_bin    <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_diff   <= {WIDTH{1'b0}};
      bus.out_bout   <= 1'b0;
      bus.out_mode   <= 1'b0;
      bus.out_cycles <= '0;
`ifdef SUB_SEQ_TIMEOUT_EN
      bus.out_err    <= 1'b0;
`endif
      bus.busy       <= 1'b0;
    end else begin
      // start is a one-cycle pulse; only the accept branch raises it
      bus.sub_start <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.sub_a     <= bus.in_a;
            bus.sub_b     <= bus.in_b;
            bus.sub_bin   <= bus.in_bin;
            bus.sub_sel   <= bus.in_mode;
            // registered here so the pulse lands exactly in the ISSUE cycle
            bus.sub_start <= bus.in_mode;
            bus.in_ready  <= 1'b0;
            bus.busy      <= 1'b1;
            state_reg     <= ISSUE;
          end else begin
            bus.in_ready  <= 1'b1;
          end
        end

        ISSUE: begin
          count_reg <= '0;
          state_reg <= WAIT;
        end

        WAIT: begin
          if (count_reg != CNT_MAX) begin
            count_reg <= count_reg + 1'b1;
          end
          if (!bus.sub_sel) begin
            bus.out_diff   <= bus.sub_diff;
            bus.out_bout   <= bus.sub_bout;
            bus.out_mode   <= 1'b0;
            bus.out_cycles <= '0;
            bus.out_valid  <= 1'b1;
            state_reg      <= HOLD;
          end else if (bus.sub_done && (count_reg != '0)) begin
            // done on the first WAIT cycle may be left over from the
            // previous serial op, hence the count_reg != 0 guard
            bus.out_diff   <= bus.sub_diff;
            bus.out_bout   <= bus.sub_bout;
            bus.out_mode   <= 1'b1;
            bus.out_cycles <= count_reg;
            bus.out_valid  <= 1'b1;
            state_reg      <= HOLD;
          end
`ifdef SUB_SEQ_TIMEOUT_EN
          else if (count_reg == TIMEOUT_CNT) begin
            bus.out_diff   <= {WIDTH{1'b0}};
            bus.out_bout   <= 1'b0;
            bus.out_mode   <= 1'b1;
            bus.out_cycles <= TIMEOUT_CNT;
            bus.out_err    <= 1'b1;
            bus.out_valid  <= 1'b1;
            state_reg      <= HOLD;
          end
`endif
        end

        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
`ifdef SUB_SEQ_TIMEOUT_EN
            bus.out_err   <= 1'b0;
`endif
            bus.busy      <= 1'b0;
            // ready rises with the return to IDLE, so the retire edge
            // itself never doubles as an accept edge
            bus.in_ready  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_op_sequencer.sv
// tb_sub_op_sequencer
//   Drives directed and random requests into sub_op_sequencer, emulates the
//   Subtractor (combinational in parallel mode, done after a programmable
//   number of cycles in serial mode) and checks every response against
//   plain 33-bit arithmetic and the expected handshake latency.
module tb_sub_op_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sub_op_sequencer_if #(.WIDTH(32), .CNT_W(8)) bus_if ();

  sub_op_sequencer #(.WIDTH(32), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // ---------------- Subtractor emulation ----------------
  int          model_lat;   // serial done latency in cycles after start; 0 = never
  int          scnt;
  logic        clr_done;
  logic [32:0] ser_res;
  logic [32:0] par_res;

  assign par_res = {1'b0, bus_if.sub_a} - {1'b0, bus_if.sub_b} - {32'b0, bus_if.sub_bin};
  assign bus_if.sub_diff = bus_if.sub_sel ? ser_res[31:0] : par_res[31:0];
  assign bus_if.sub_bout = bus_if.sub_sel ? ser_res[32]   : par_res[32];

  always @(posedge clk) begin
    if (reset) begin
      scnt            <= 0;
      clr_done        <= 1'b0;
      ser_res         <= '0;
      bus_if.sub_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      // done from the previous op lingers one cycle past start
      if (clr_done) bus_if.sub_done <= 1'b0;
      if (bus_if.sub_start) begin
        scnt     <= 1;
        clr_done <= 1'b1;
      end else if (scnt != 0) begin
        if (model_lat != 0 && scnt == model_lat) begin
          bus_if.sub_done <= 1'b1;
          ser_res         <= par_res;
          scnt            <= 0;
        end else begin
          scnt <= scnt + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns at the same phase.
  task automatic wait_ready();
    int n;
    n = 0;
    while (bus_if.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("in_ready_wait", 64'(bus_if.in_ready), 64'd1);
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic mode, input int lat);
    wait_ready();
    model_lat      = lat;
    bus_if.in_a    = a;
    bus_if.in_b    = b;
    bus_if.in_bin  = bin;
    bus_if.in_mode = mode;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input logic mode,
                        input int lat, input int hold);
    logic [32:0] ref_res;
    logic [31:0] d0;
    int          n;
    int          starts;
    bit          stable;
    accept(a, b, bin, mode, lat);
    n      = 1;
    starts = int'(bus_if.sub_start);
    check("sub_a_latched", 64'(bus_if.sub_a), 64'(a));
    check("sub_sel_latched", 64'(bus_if.sub_sel), 64'(mode));
    while (bus_if.out_valid !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
      starts += int'(bus_if.sub_start);
    end
    ref_res = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    check("latency", 64'(n), mode ? 64'(3 + lat) : 64'd3);
    check("out_diff", 64'(bus_if.out_diff), 64'(ref_res[31:0]));
    check("out_bout", 64'(bus_if.out_bout), 64'(ref_res[32]));
    check("out_cycles", 64'(bus_if.out_cycles), mode ? 64'(lat) : 64'd0);
    check("out_mode", 64'(bus_if.out_mode), 64'(mode));
    check("out_err", 64'(bus_if.out_err), 64'd0);
    check("start_pulses", 64'(starts), 64'(mode));
    check("in_ready_hold", 64'(bus_if.in_ready), 64'd0);
    check("busy_hold", 64'(bus_if.busy), 64'd1);
    stable = 1'b1;
    d0     = bus_if.out_diff;
    for (int i = 0; i < hold; i++) begin
      // a competing request must not be taken while the response is pending
      bus_if.in_valid = 1'b1;
      bus_if.in_a     = ~a;
      @(posedge clk); #1;
      if (bus_if.out_diff !== d0 || bus_if.out_valid !== 1'b1 ||
          bus_if.in_ready !== 1'b0 || bus_if.sub_a !== a) stable = 1'b0;
    end
    bus_if.in_valid = 1'b0;
    if (hold > 0) check("backpressure_stable", 64'(stable), 64'd1);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check("retire_valid", 64'(bus_if.out_valid), 64'd0);
    check("retire_busy", 64'(bus_if.busy), 64'd0);
    $display("op a=%08h b=%08h bin=%0d mode=%0d lat=%0d hold=%0d -> diff=%08h bout=%0d cycles=%0d latency=%0d",
             a, b, bin, mode, lat, hold, d0, ref_res[32], bus_if.out_cycles, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int n;
    reset            = 1'b1;
    model_lat        = 0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = '0;
    bus_if.in_b      = '0;
    bus_if.in_bin    = 1'b0;
    bus_if.in_mode   = 1'b0;
    bus_if.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus_if.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_sub_start", 64'(bus_if.sub_start), 64'd0);
    check("rst_out_err", 64'(bus_if.out_err), 64'd0);
    check("rst_out_cycles", 64'(bus_if.out_cycles), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 64'(bus_if.in_ready), 64'd1);

    // directed cases
    run_op(32'd100, 32'd25, 1'b0, 1'b0, 0, 0);
    run_op(32'd10, 32'd30, 1'b0, 1'b0, 0, 0);
    run_op(32'd150, 32'd75, 1'b1, 1'b1, 32, 0);
    run_op(32'd1234, 32'd234, 1'b0, 1'b0, 0, 5);
    run_op(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 1, 2);

    // random traffic
    for (int i = 0; i < 20; i++) begin
      logic m;
      m = 1'($urandom_range(1, 0));
      run_op($urandom, $urandom, 1'($urandom_range(1, 0)), m,
             m ? int'($urandom_range(40, 1)) : 0, int'($urandom_range(3, 0)));
    end

    // serial op whose done never comes
    accept(32'd7, 32'd3, 1'b0, 1'b1, 0);
`ifdef SUB_SEQ_TIMEOUT_EN
    n = 1;
    while (bus_if.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_latency", 64'(n), 64'd43);
    check("timeout_err", 64'(bus_if.out_err), 64'd1);
    check("timeout_cycles", 64'(bus_if.out_cycles), 64'd40);
    check("timeout_diff", 64'(bus_if.out_diff), 64'd0);
    check("timeout_bout", 64'(bus_if.out_bout), 64'd0);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    check("timeout_err_clear", 64'(bus_if.out_err), 64'd0);
    $display("op stuck-done serial -> timeout after %0d cycles", n);
`else
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid !== 1'b0 || bus_if.busy !== 1'b1) ok = 1'b0;
    end
    check("stuck_waits", 64'(ok), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("stuck_reset_busy", 64'(bus_if.busy), 64'd0);
    $display("op stuck-done serial -> held in WAIT, cleared by reset");
`endif

    // reset in the middle of a serial WAIT
    accept(32'd500, 32'd1, 1'b0, 1'b1, 30);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", 64'(bus_if.busy), 64'd0);
    check("midreset_valid", 64'(bus_if.out_valid), 64'd0);
    check("midreset_in_ready", 64'(bus_if.in_ready), 64'd0);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid !== 1'b0) ok = 1'b0;
    end
    check("midreset_no_response", 64'(ok), 64'd1);
    $display("op serial aborted by reset mid-WAIT");
    run_op(32'd50, 32'd50, 1'b0, 1'b0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
